// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_pkg                                                        |
// | Shared types and constants for the MEM-stage load unit.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_align_extend                                                    |
// | Byte-lane shift of a read beat, size select and zero/sign extension. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_align_extend
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = clog2_f(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_beat,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_low_mask;
    logic              w_sign;

    always_comb begin
        w_shifted = i_beat >> {i_lane, 3'b000};
        case (i_size)
            SIZE_BYTE: begin
                w_low_mask = DATA_W'(8'hFF);
                w_sign     = w_shifted[7];
            end
            SIZE_HALF: begin
                w_low_mask = DATA_W'(16'hFFFF);
                w_sign     = w_shifted[15];
            end
            SIZE_WORD: begin
                w_low_mask = DATA_W'(32'hFFFF_FFFF);
                w_sign     = w_shifted[31];
            end
            default: begin
                w_low_mask = '1;
                w_sign     = w_shifted[DATA_W-1];
            end
        endcase
        // Bits above the selected size are either cleared or filled with the sign.
        o_data = (w_shifted & w_low_mask) |
                 ((w_sign && !i_unsigned) ? ~w_low_mask : '0);
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_load_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_load_unit                                                  |
// | MEM-stage load: one AXI line burst per load, extract and extend.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_stage_load_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mem,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              wb_accept,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast
);

    localparam int BYTE_W     = clog2_f(DATA_W / 8);
    localparam int LINE_BYTES = LINE_BEATS * (DATA_W / 8);
    localparam int OFF_W      = clog2_f(LINE_BYTES);
    localparam int CNT_W      = clog2_f(LINE_BEATS) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic                w_misalign;
    logic                w_illegal;
    logic [CNT_W-1:0]    w_word_idx;
    logic                w_hit;
    logic                w_last;
    logic [DATA_W-1:0]   w_beat_sel;
    logic [DATA_W-1:0]   w_extracted;

    always_comb begin
        case (req_size)
            SIZE_HALF:  w_misalign = req_addr[0];
            SIZE_WORD:  w_misalign = |req_addr[1:0];
            SIZE_DWORD: w_misalign = |req_addr[2:0];
            default:    w_misalign = 1'b0;
        endcase
        w_illegal  = (DATA_W == 32) && (req_size == SIZE_DWORD);
        w_word_idx = CNT_W'(addr_q[OFF_W-1:0] >> BYTE_W);
        w_hit      = m_axi_rvalid && (cnt_q == w_word_idx);
        w_last     = m_axi_rlast || (cnt_q == LAST_CNT);
        // The wanted beat may be the final one, so bypass the capture register.
        w_beat_sel = w_hit ? m_axi_rdata : beat_q;
    end

    load_align_extend #(
        .DATA_W (DATA_W),
        .LANE_W (BYTE_W)
    ) u_align (
        .i_beat     (w_beat_sel),
        .i_lane     (addr_q[BYTE_W-1:0]),
        .i_size     (size_q),
        .i_unsigned (unsigned_q),
        .o_data     (w_extracted)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_mem || w_misalign || w_illegal) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_axi_rvalid && w_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wb_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        m_axi_arvalid = (state_q == ST_ADDR);
        m_axi_rready  = (state_q == ST_DATA);
        resp_valid    = (state_q == ST_HOLD);
        resp_err      = (state_q == ST_HOLD) && err_q;
        resp_data     = resp_data_q;
        m_axi_araddr  = addr_q & ~LINE_MASK;
        m_axi_arlen   = 8'(LINE_BEATS - 1);
        m_axi_arsize  = 3'(BYTE_W);
        m_axi_arburst = AXI_BURST_INCR;
    end

    always_comb begin
        addr_d      = addr_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        beat_d      = beat_q;
        resp_data_d = resp_data_q;
        if (state_q == ST_IDLE && req_valid) begin
            cnt_d       = '0;
            resp_data_d = '0;
            err_d       = req_mem && (w_misalign || w_illegal);
            if (req_mem) begin
                addr_d     = req_addr;
                size_d     = req_size;
                unsigned_d = req_unsigned;
            end
        end else if (state_q == ST_DATA && m_axi_rvalid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (w_hit) begin
                beat_d = m_axi_rdata;
            end
            // Sticky: bad response, early rlast, or rlast missing on the final beat.
            if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != (cnt_q == LAST_CNT))) begin
                err_d = 1'b1;
            end
            if (w_last) begin
                resp_data_d = w_extracted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            resp_data_q <= '0;
        end else begin
            addr_q      <= addr_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_load_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage_load_unit                                               |
// | Directed bench with an expected-result queue for the load unit.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_stage_load_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_mem;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        wb_accept;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] tb_beats [0:7];
    int          checks;
    int          failures;
    int          cyc;

    mem_stage_load_unit #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .LINE_BEATS (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mem       (req_mem),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .wb_accept     (wb_accept),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-wise reference: gather the addressed bytes, then fill upward.
    function automatic logic [63:0] model(input logic [63:0] beat, input int lane,
                                          input int size, input bit uns);
        logic [63:0] v;
        int n;
        n = 1 << size;
        v = '0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = beat[8*(lane+b) +: 8];
        if (!uns && v[8*n-1]) for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic run_req(input string tag, input bit mem, input logic [63:0] addr,
                           input logic [1:0] size, input bit uns, input int ar_delay,
                           input int err_beat, input int rlast_beat, input int hold,
                           input bit use_const, input logic [63:0] const_data);
        exp_t        e;
        exp_t        got;
        bit          aligned;
        bit          axi;
        int          exp_lat;
        int          t0;
        int          n;
        logic [63:0] line;
        aligned = ((addr & ((64'd1 << size) - 64'd1)) == 64'd0);
        axi     = mem && aligned;
        line    = {addr[63:6], 6'b0};
        e.err   = !mem ? 1'b0 : !aligned ? 1'b1 : ((err_beat < 8) || (rlast_beat != 7));
        e.data  = !axi ? 64'd0 : use_const ? const_data
                                : model(tb_beats[addr[5:3]], int'(addr[2:0]), int'(size), uns);
        exp_lat = !axi ? 1 : ((rlast_beat < 7) ? rlast_beat : 7) + 3 + ar_delay;

        check({tag, "_req_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_mem = mem; req_addr = addr;
        req_size = size; req_unsigned = uns;
        sb.push_back(e);
        t0 = cyc;
        step();
        req_valid = 1'b0;

        if (!axi) begin
            check({tag, "_no_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        end else begin
            check({tag, "_arvalid_c1"}, 64'(m_axi_arvalid), 64'd1);
            for (int w = 0; w <= ar_delay; w++) begin
                check({tag, "_araddr"}, m_axi_araddr, line);
                check({tag, "_arlen"}, 64'(m_axi_arlen), 64'd7);
                check({tag, "_arsize"}, 64'(m_axi_arsize), 64'd3);
                check({tag, "_arburst"}, 64'(m_axi_arburst), 64'd1);
                check({tag, "_ar_req_ready"}, 64'(req_ready), 64'd0);
                if (w == ar_delay) m_axi_arready = 1'b1;
                step();
                m_axi_arready = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = tb_beats[i];
                m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast  = (i == rlast_beat);
                check({tag, "_rready"}, 64'(m_axi_rready), 64'd1);
                step();
                if (i == rlast_beat) break;
            end
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
        end

        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
            check({tag, "_hold_data"}, resp_data, e.data);
            step();
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            check({tag, "_resp_data"}, resp_data, got.data);
            check({tag, "_resp_err"}, 64'(resp_err), 64'(got.err));
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        check({tag, "_post_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_post_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic fill_beats();
        for (int i = 0; i < 8; i++) tb_beats[i] = {$urandom(), $urandom()};
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1; req_valid = 1'b0; req_mem = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; wb_accept = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        step(); step();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        reset = 1'b0;
        step();

        fill_beats();
        tb_beats[2] = 64'hABCD_0000_0000_0000;
        run_req("half_signed", 1, 64'h1016, 2'd1, 0, 0, 8, 7, 0, 1, 64'hFFFF_FFFF_FFFF_ABCD);
        run_req("half_unsigned", 1, 64'h1016, 2'd1, 1, 0, 8, 7, 0, 1, 64'h0000_0000_0000_ABCD);
        run_req("misaligned", 1, 64'h1003, 2'd2, 0, 0, 8, 7, 0, 0, 64'd0);
        fill_beats();
        run_req("rresp_err", 1, 64'h2028, 2'd3, 0, 0, 5, 7, 0, 0, 64'd0);
        run_req("passthru_hold", 0, 64'h5555, 2'd3, 0, 0, 8, 7, 5, 0, 64'd0);
        fill_beats();
        tb_beats[0] = 64'h0000_0000_0000_8000;
        run_req("ar_delay", 1, 64'h3001, 2'd0, 0, 3, 8, 7, 0, 0, 64'd0);
        fill_beats();
        run_req("early_rlast", 1, 64'h4010, 2'd3, 0, 0, 8, 4, 0, 0, 64'd0);
        run_req("missing_rlast", 1, 64'h4010, 2'd2, 0, 0, 8, 8, 0, 0, 64'd0);
        fill_beats();
        tb_beats[7][63] = 1'b1;
        run_req("word_last_beat", 1, 64'h007C, 2'd2, 1, 0, 8, 7, 0, 0, 64'd0);
        run_req("word_last_signed", 1, 64'h007C, 2'd2, 0, 0, 8, 7, 0, 0, 64'd0);

        // Reset while beat 3 is on the bus.
        fill_beats();
        req_valid = 1'b1; req_mem = 1'b1; req_addr = 64'h0100; req_size = 2'd3;
        step();
        req_valid = 1'b0;
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = tb_beats[i];
            if (i == 3) reset = 1'b1;
            step();
        end
        check("rst_mid_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_mid_rready", 64'(m_axi_rready), 64'd0);
        check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        m_axi_rvalid = 1'b0;
        step();

        fill_beats();
        run_req("after_reset", 1, 64'h2035, 2'd0, 0, 0, 8, 7, 0, 0, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
